// File: rtl/andn_qual_if.sv
// andn_qual_if: control inputs and qualified outputs of the andn_qual gate.
interface andn_qual_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 CE;
  logic [WIDTH-1:0]     I;
  logic                 CNT_CLR;
  logic                 O;
  logic                 RISE;
  logic [CNT_WIDTH-1:0] CNT;
  modport master (output CE, I, CNT_CLR, input O, RISE, CNT);
  modport slave  (input CE, I, CNT_CLR, output O, RISE, CNT);
endinterface

// File: rtl/andn_qual.sv
// andn_qual: registered AND of optionally inverted inputs, qualified over
// QUAL_CYCLES consecutive matches, with a rise pulse and saturating event count.
module andn_qual #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   INV_MASK    = 4'b0111,
  parameter int                 QUAL_CYCLES = 1,
  parameter int                 CNT_WIDTH   = 8
) (
  input logic         C,
  input logic         CLR_N,
  andn_qual_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, QUAL, ACTIVE} state_t;
  localparam logic [7:0] QMAX = 8'(QUAL_CYCLES);
  state_t               state, state_nxt;
  logic [7:0]           qc, qc_nxt;
  logic [WIDTH-1:0]     ir;
  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 match, enter;
  assign match = &(ir ^ INV_MASK);
  always_comb begin
    state_nxt = state;
    qc_nxt    = qc;
    case (state)
      IDLE: if (match) begin
        state_nxt = (QUAL_CYCLES == 1) ? ACTIVE : QUAL;
        qc_nxt    = (QUAL_CYCLES == 1) ? 8'd0 : 8'd1;
      end
      QUAL: if (!match) begin
        state_nxt = IDLE;
        qc_nxt    = 8'd0;
      end else if (qc + 8'd1 == QMAX) begin
        state_nxt = ACTIVE;
        qc_nxt    = 8'd0;
      end else begin
        qc_nxt = qc + 8'd1;
      end
      ACTIVE: state_nxt = match ? ACTIVE : IDLE;
      default: begin
        state_nxt = IDLE;
        qc_nxt    = 8'd0;
      end
    endcase
  end
  assign enter = bus.CE && state != ACTIVE && state_nxt == ACTIVE;
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      ir    <= '0;
      state <= IDLE;
      qc    <= 8'd0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      if (bus.CE) begin
        ir    <= bus.I;
        state <= state_nxt;
        qc    <= qc_nxt;
      end
      rise <= enter;
      // clear beats a coincident increment; the rise pulse is unaffected
      if (bus.CNT_CLR) cnt <= '0;
      else if (enter && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
  assign bus.O    = state == ACTIVE;
  assign bus.RISE = rise;
  assign bus.CNT  = cnt;
endmodule

// File: tb/tb_andn_qual.sv
// tb_andn_qual: directed checks of andn_qual across four parameter sets
// driven from one shared stimulus.
module tb_andn_qual;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [3:0] i = 4'd0;
  logic       cnt_clr = 1'b0;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  andn_qual_if #(.WIDTH(4), .CNT_WIDTH(8)) if0 ();
  andn_qual_if #(.WIDTH(4), .CNT_WIDTH(8)) if1 ();
  andn_qual_if #(.WIDTH(4), .CNT_WIDTH(2)) if2 ();
  andn_qual_if #(.WIDTH(4), .CNT_WIDTH(8)) if3 ();
  assign {if0.CE, if0.I, if0.CNT_CLR} = {ce, i, cnt_clr};
  assign {if1.CE, if1.I, if1.CNT_CLR} = {ce, i, cnt_clr};
  assign {if2.CE, if2.I, if2.CNT_CLR} = {ce, i, cnt_clr};
  assign {if3.CE, if3.I, if3.CNT_CLR} = {ce, i, cnt_clr};
  andn_qual dut0 (.C(clk), .CLR_N(rst_n), .bus(if0.slave));
  andn_qual #(.QUAL_CYCLES(3)) dut1 (.C(clk), .CLR_N(rst_n), .bus(if1.slave));
  andn_qual #(.CNT_WIDTH(2)) dut2 (.C(clk), .CLR_N(rst_n), .bus(if2.slave));
  andn_qual #(.QUAL_CYCLES(4)) dut3 (.C(clk), .CLR_N(rst_n), .bus(if3.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ce = 1'b1;
    i = 4'd0;
    cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [3:0] others [5] = '{4'b0000, 4'b1111, 4'b0111, 4'b1001, 4'b1100};
    #2;
    check("rst_o", {31'd0, if0.O}, 0);
    check("rst_rise", {31'd0, if0.RISE}, 0);
    check("rst_cnt", {24'd0, if0.CNT}, 0);
    do_reset();
    // default parameters: 1000 is the only matching pattern
    i = 4'b1000;
    step();
    check("d_cap_o", {31'd0, if0.O}, 0);
    step();
    check("d_o", {31'd0, if0.O}, 1);
    check("d_rise", {31'd0, if0.RISE}, 1);
    check("d_cnt", {24'd0, if0.CNT}, 1);
    step();
    check("d_rise_drop", {31'd0, if0.RISE}, 0);
    check("d_o_hold", {31'd0, if0.O}, 1);
    i = 4'b0000;
    step();
    check("d_deas_k", {31'd0, if0.O}, 1);
    step();
    check("d_deas_k1", {31'd0, if0.O}, 0);
    check("d_cnt_keep", {24'd0, if0.CNT}, 1);
    foreach (others[n]) begin
      i = others[n];
      step();
      step();
      step();
      check("d_other_o", {31'd0, if0.O}, 0);
    end
    check("d_other_cnt", {24'd0, if0.CNT}, 1);
    // QUAL_CYCLES=3: two-cycle glitch is rejected, three cycles qualify
    do_reset();
    i = 4'b1000;
    step();
    step();
    i = 4'b0000;
    step();
    check("q3_glitch_k2", {31'd0, if1.O}, 0);
    step();
    step();
    check("q3_glitch_o", {31'd0, if1.O}, 0);
    check("q3_glitch_cnt", {24'd0, if1.CNT}, 0);
    i = 4'b1000;
    step();
    step();
    step();
    check("q3_k2_o", {31'd0, if1.O}, 0);
    step();
    check("q3_k3_o", {31'd0, if1.O}, 1);
    check("q3_k3_rise", {31'd0, if1.RISE}, 1);
    check("q3_k3_cnt", {24'd0, if1.CNT}, 1);
    // CNT_WIDTH=2 saturates at 3
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      i = 4'b1000;
      step();
      step();
      check("sat_o", {31'd0, if2.O}, 1);
      check("sat_cnt", {30'd0, if2.CNT}, (n < 3) ? n : 3);
      i = 4'b0000;
      step();
      step();
      check("sat_o_low", {31'd0, if2.O}, 0);
    end
    // clear coinciding with ACTIVE entry
    do_reset();
    i = 4'b1000;
    step();
    step();
    i = 4'b0000;
    step();
    step();
    check("clr_pre_cnt", {24'd0, if0.CNT}, 1);
    i = 4'b1000;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_o", {31'd0, if0.O}, 1);
    check("clr_rise", {31'd0, if0.RISE}, 1);
    check("clr_cnt", {24'd0, if0.CNT}, 0);
    // QUAL_CYCLES=4 frozen by CE=0 with QC=2; input changes ignored meanwhile
    do_reset();
    i = 4'b1000;
    step();
    step();
    step();
    ce = 1'b0;
    i = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      step();
      check("ce_frz_o", {31'd0, if3.O}, 0);
      check("ce_frz_cnt", {24'd0, if3.CNT}, 0);
    end
    ce = 1'b1;
    i = 4'b1000;
    step();
    check("ce_res1_o", {31'd0, if3.O}, 0);
    step();
    check("ce_res2_o", {31'd0, if3.O}, 1);
    check("ce_res2_rise", {31'd0, if3.RISE}, 1);
    check("ce_res2_cnt", {24'd0, if3.CNT}, 1);
    // async reset between edges while active with CNT=5
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      i = 4'b1000;
      step();
      step();
      if (n < 5) begin
        i = 4'b0000;
        step();
        step();
      end
    end
    check("ar_pre_o", {31'd0, if0.O}, 1);
    check("ar_pre_cnt", {24'd0, if0.CNT}, 5);
    #2 rst_n = 1'b0;
    #1;
    check("ar_o", {31'd0, if0.O}, 0);
    check("ar_cnt", {24'd0, if0.CNT}, 0);
    #2 rst_n = 1'b1;
    #1;
    check("ar_rel_rise", {31'd0, if0.RISE}, 0);
    step();
    check("ar_cap_o", {31'd0, if0.O}, 0);
    check("ar_cap_rise", {31'd0, if0.RISE}, 0);
    step();
    check("ar_new_o", {31'd0, if0.O}, 1);
    check("ar_new_cnt", {24'd0, if0.CNT}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
